// File: rtl/rom_stream_reader.sv
// Read-side master for a single-address registered ROM. It streams LEN words from START_ADDR
// out as a valid/ready stream with a last marker, buffered by a small FIFO.
module rom_stream_reader #(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              issue_last_q, issue_last_d;
    logic              cap_q, cap_d;
    logic              cap_last_q, cap_last_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W:0]    occupancy;
    logic              push, pop;

    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic              mem_last [FIFO_DEPTH];

    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign m_valid  = (count_q != '0);
    assign m_data   = m_valid ? mem_data[rd_ptr_q] : '0;
    assign m_last   = m_valid ? mem_last[rd_ptr_q] : 1'b0;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

    always_comb begin
        state_d      = state_q;
        rom_en_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        next_addr_d  = next_addr_q;
        remaining_d  = remaining_q;
        issue_last_d = issue_last_q;
        // rom_data is only meaningful the cycle after an enable; the tag follows it
        cap_d        = rom_en_q;
        cap_last_d   = issue_last_q;
        push         = cap_q;
        pop          = m_valid && m_ready;
        occupancy    = {1'b0, count_q} + (CNT_W+1)'(rom_en_q) + (CNT_W+1)'(cap_q);

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        rom_en_d     = 1'b1;
                        rom_addr_d   = start_addr;
                        next_addr_d  = start_addr + ADDR_W'(1);
                        remaining_d  = len - (ADDR_W+1)'(1);
                        issue_last_d = (len == (ADDR_W+1)'(1));
                        state_d      = (len == (ADDR_W+1)'(1)) ? DRAIN : READ;
                    end
                end
            end
            READ: begin
                // Reads in flight are counted against the FIFO so it can never overflow
                if (occupancy < (CNT_W+1)'(FIFO_DEPTH)) begin
                    rom_en_d     = 1'b1;
                    rom_addr_d   = next_addr_q;
                    next_addr_d  = next_addr_q + ADDR_W'(1);
                    remaining_d  = remaining_q - (ADDR_W+1)'(1);
                    issue_last_d = (remaining_q == (ADDR_W+1)'(1));
                    if (remaining_q == (ADDR_W+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        if (abort && state_q != IDLE) begin
            state_d  = IDLE;
            rom_en_d = 1'b0;
            cap_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            next_addr_q  <= '0;
            remaining_q  <= '0;
            issue_last_q <= 1'b0;
            cap_q        <= 1'b0;
            cap_last_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            next_addr_q  <= next_addr_d;
            remaining_q  <= remaining_d;
            issue_last_q <= issue_last_d;
            cap_q        <= cap_d;
            cap_last_q   <= cap_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= rom_data;
            mem_last[wr_ptr_q] <= cap_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count_q == CNT_W'(FIFO_DEPTH)));
        end
    end
endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader against an 8x16 registered ROM model.
module tb_rom_stream_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  start_addr = '0;
    logic [3:0]  len = '0;
    logic        abort = 1'b0;
    logic        rom_en;
    logic [2:0]  rom_addr;
    logic [15:0] rom_data = 16'hDEAD;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    logic [15:0] rom_mem [8] = '{16'haaaa, 16'habcd, 16'h9999, 16'h2121,
                                 16'h8585, 16'h4258, 16'h7b4e, 16'h9a2b};

    beat_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int en_cnt = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int done_cyc = -1;
    logic        hold_pending = 1'b0;
    logic [15:0] hold_data = '0;
    logic        hold_last = 1'b0;

    rom_stream_reader #(.ADDR_W(3), .DATA_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
        .abort(abort), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Registered ROM: data valid only the cycle after an enable, poison otherwise
    always @(posedge clk) rom_data <= rom_en ? rom_mem[rom_addr] : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (rom_en) en_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (hold_pending) begin
                chk("hold_valid", {31'b0, m_valid}, 32'd1);
                chk("hold_data", {16'b0, m_data}, {16'b0, hold_data});
                chk("hold_last", {31'b0, m_last}, {31'b0, hold_last});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {16'b0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", {16'b0, m_data}, {16'b0, e.d});
                    chk("beat_last", {31'b0, m_last}, {31'b0, e.l});
                end
                beat_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                if (m_last) last_cyc = cyc;
            end
            hold_pending = m_valid && !m_ready && !abort;
            hold_data = m_data;
            hold_last = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] a, input logic [3:0] n);
        for (int i = 0; i < int'(n); i++) begin
            logic [2:0] ai;
            ai = a + 3'(i);
            exp_q.push_back(beat_t'{d: rom_mem[ai], l: (i == int'(n) - 1)});
        end
        first_cyc = -1;
        start_addr = a;
        len = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            tick();
            i++;
        end
        chk(name, {31'b0, done_cnt != d0}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rom_en"},   {31'b0, rom_en}, 32'd0);
        chk({tag, "_rom_addr"}, {29'b0, rom_addr}, 32'd0);
        chk({tag, "_m_valid"},  {31'b0, m_valid}, 32'd0);
        chk({tag, "_m_last"},   {31'b0, m_last}, 32'd0);
        chk({tag, "_m_data"},   {16'b0, m_data}, 32'd0);
        chk({tag, "_busy"},     {31'b0, busy}, 32'd0);
        chk({tag, "_done"},     {31'b0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, b0, d0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic transfer with latency and done timing
        m_ready = 1'b1;
        e0 = en_cnt; b0 = beat_cnt; d0 = done_cnt;
        do_start(3'd2, 4'd3);
        chk("t1_rom_en", {31'b0, rom_en}, 32'd1);
        chk("t1_rom_addr", {29'b0, rom_addr}, 32'd2);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("t1_valid_early", {31'b0, m_valid}, 32'd0);
        tick();
        chk("t1_valid_lat", {31'b0, m_valid}, 32'd1);
        chk("t1_first_data", {16'b0, m_data}, 32'h9999);
        wait_done(20, "t1_done_timeout");
        chk("t1_done_after_last", done_cyc, last_cyc + 1);
        chk("t1_en_count", en_cnt - e0, 32'd3);
        chk("t1_beats", beat_cnt - b0, 32'd3);
        chk("t1_done_count", done_cnt - d0, 32'd1);
        chk("t1_idle", {31'b0, busy}, 32'd0);

        // Full-depth transfer with wrap, one beat per cycle
        e0 = en_cnt; b0 = beat_cnt;
        do_start(3'd6, 4'd8);
        wait_done(30, "t2_done_timeout");
        chk("t2_en_count", en_cnt - e0, 32'd8);
        chk("t2_beats", beat_cnt - b0, 32'd8);
        chk("t2_contiguous", last_cyc - first_cyc, 32'd7);

        // Backpressure: issue stalls at FIFO capacity
        m_ready = 1'b0;
        e0 = en_cnt; b0 = beat_cnt;
        do_start(3'd0, 4'd5);
        repeat (6) tick();
        chk("t3_en_stalled", en_cnt - e0, 32'd4);
        chk("t3_valid", {31'b0, m_valid}, 32'd1);
        chk("t3_head", {16'b0, m_data}, 32'haaaa);
        chk("t3_rom_en_low", {31'b0, rom_en}, 32'd0);
        m_ready = 1'b1;
        wait_done(30, "t3_done_timeout");
        chk("t3_en_total", en_cnt - e0, 32'd5);
        chk("t3_beats", beat_cnt - b0, 32'd5);

        // Zero-length request
        e0 = en_cnt; b0 = beat_cnt; d0 = done_cnt;
        do_start(3'd3, 4'd0);
        chk("t4_busy", {31'b0, busy}, 32'd1);
        chk("t4_done", {31'b0, done}, 32'd1);
        chk("t4_rom_en", {31'b0, rom_en}, 32'd0);
        tick();
        chk("t4_busy_clear", {31'b0, busy}, 32'd0);
        chk("t4_done_clear", {31'b0, done}, 32'd0);
        repeat (3) tick();
        chk("t4_en_none", en_cnt - e0, 32'd0);
        chk("t4_beats_none", beat_cnt - b0, 32'd0);
        chk("t4_done_once", done_cnt - d0, 32'd1);

        // Abort one cycle after first valid
        m_ready = 1'b0;
        d0 = done_cnt;
        do_start(3'd0, 4'd8);
        begin
            int i;
            i = 0;
            while (!m_valid && i < 10) begin
                tick();
                i++;
            end
            chk("t5_valid_timeout", {31'b0, m_valid}, 32'd1);
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_valid", {31'b0, m_valid}, 32'd0);
        chk("t5_rom_en", {31'b0, rom_en}, 32'd0);
        repeat (3) tick();
        chk("t5_valid_stays", {31'b0, m_valid}, 32'd0);
        chk("t5_no_done", done_cnt - d0, 32'd0);
        start_addr = 3'd4; len = 4'd2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t5_abort_wins", {31'b0, busy}, 32'd0);
        m_ready = 1'b1;
        b0 = beat_cnt;
        do_start(3'd1, 4'd1);
        wait_done(20, "t5_done_timeout");
        chk("t5_beats", beat_cnt - b0, 32'd1);

        // Reset mid-transfer, then start-while-busy ignored
        d0 = done_cnt;
        do_start(3'd4, 4'd8);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("t6");
        rst = 1'b0;
        exp_q.delete();
        tick();
        chk("t6_no_done", done_cnt - d0, 32'd0);
        e0 = en_cnt; b0 = beat_cnt; d0 = done_cnt;
        do_start(3'd5, 4'd3);
        tick();
        start_addr = 3'd0; len = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, "t6_done_timeout");
        chk("t6_en_count", en_cnt - e0, 32'd3);
        chk("t6_beats", beat_cnt - b0, 32'd3);
        chk("t6_done_count", done_cnt - d0, 32'd1);
        repeat (3) tick();
        chk("t6_idle", {31'b0, busy}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
